// File: rtl/iq_axis_decimator.sv
`default_nettype none
// ============================================================================
// Module   : iq_axis_decimator
// Purpose  : Two-channel boxcar decimator (2^k averaging) feeding an AXI4-Stream
//            master through a 2-entry first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module iq_axis_decimator #(
    parameter int DATA_WIDTH   = 48,
    parameter int CH_WIDTH     = 24,
    parameter int MAX_LOG2_DEC = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic [3:0]            dec_log2,
    input  logic                  clear_ovf,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overflow
);

    localparam int               c_ACC_W = CH_WIDTH + MAX_LOG2_DEC;
    localparam int               c_CNT_W = MAX_LOG2_DEC;
    localparam logic [3:0]       c_MAX_K = 4'(MAX_LOG2_DEC);
    localparam logic [c_CNT_W-1:0] c_ONES = {c_CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Accumulation datapath
    // ------------------------------------------------------------------
    logic        [3:0]          r_k;
    logic        [c_CNT_W-1:0]  r_cnt;
    logic signed [c_ACC_W-1:0]  r_acc_a;
    logic signed [c_ACC_W-1:0]  r_acc_b;

    logic        [3:0]          w_dec_clamped;
    logic        [3:0]          w_k;
    logic        [c_CNT_W-1:0]  w_last_cnt;
    logic                       w_block_end;
    logic signed [c_ACC_W-1:0]  w_ext_a;
    logic signed [c_ACC_W-1:0]  w_ext_b;
    logic signed [c_ACC_W-1:0]  w_sum_a;
    logic signed [c_ACC_W-1:0]  w_sum_b;
    logic        [CH_WIDTH-1:0] w_avg_a;
    logic        [CH_WIDTH-1:0] w_avg_b;

    assign w_dec_clamped = (dec_log2 > c_MAX_K) ? c_MAX_K : dec_log2;
    // The first sample of a block already uses the freshly latched exponent.
    assign w_k           = (r_cnt == '0) ? w_dec_clamped : r_k;
    assign w_last_cnt    = ~(c_ONES << w_k);
    assign w_block_end   = s_valid && (r_cnt == w_last_cnt);

    assign w_ext_a = {{MAX_LOG2_DEC{s_data[CH_WIDTH-1]}}, s_data[CH_WIDTH-1:0]};
    assign w_ext_b = {{MAX_LOG2_DEC{s_data[2*CH_WIDTH-1]}}, s_data[2*CH_WIDTH-1:CH_WIDTH]};
    assign w_sum_a = r_acc_a + w_ext_a;
    assign w_sum_b = r_acc_b + w_ext_b;
    assign w_avg_a = CH_WIDTH'(w_sum_a >>> w_k);
    assign w_avg_b = CH_WIDTH'(w_sum_b >>> w_k);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_k     <= '0;
            r_cnt   <= '0;
            r_acc_a <= '0;
            r_acc_b <= '0;
        end else if (s_valid) begin
            if (r_cnt == '0) begin
                r_k <= w_dec_clamped;
            end
            if (w_block_end) begin
                r_cnt   <= '0;
                r_acc_a <= '0;
                r_acc_b <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_acc_a <= w_sum_a;
                r_acc_b <= w_sum_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry FWFT output FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_overflow;

    logic                  w_pop;
    logic                  w_accept;
    logic                  w_drop;

    assign w_pop    = (r_count != 2'd0) && m_axis_tready;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign w_accept = w_block_end && ((r_count != 2'd2) || w_pop);
    assign w_drop   = w_block_end && !w_accept;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= {w_avg_b, w_avg_a};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_iq_axis_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_axis_decimator
// Purpose  : Directed self-checking bench for iq_axis_decimator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_axis_decimator;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [47:0] s_data;
    logic        s_valid;
    logic [3:0]  dec_log2;
    logic        clear_ovf;
    logic [47:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    iq_axis_decimator #(
        .DATA_WIDTH  (48),
        .CH_WIDTH    (24),
        .MAX_LOG2_DEC(10)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .dec_log2     (dec_log2),
        .clear_ovf    (clear_ovf),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [23:0] a, input logic [23:0] b);
        return {16'h0, b, a};
    endfunction

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample(input logic [23:0] a, input logic [23:0] b);
        s_data  = {b, a};
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        aresetn       = 1'b0;
        s_data        = '0;
        s_valid       = 1'b0;
        dec_log2      = 4'd0;
        clear_ovf     = 1'b0;
        m_axis_tready = 1'b1;

        // Reset and idle
        repeat (3) step();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        aresetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("idle_tdata", 64'(m_axis_tdata), 64'd0);
            check("idle_ovf", 64'(overflow), 64'd0);
        end

        // Pass-through, single then back-to-back
        sample(24'h000005, 24'hFFFFFD);
        check("pt_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("pt_tdata", 64'(m_axis_tdata), 64'hFFFFFD_000005);
        for (int i = 1; i <= 4; i++) begin
            sample(24'(i * 3), 24'(-i));
            check("pt_b2b_tvalid", 64'(m_axis_tvalid), 64'd1);
            check("pt_b2b_tdata", 64'(m_axis_tdata), pk(24'(i * 3), 24'(-i)));
        end
        step();
        check("pt_drain", 64'(m_axis_tvalid), 64'd0);

        // Averaging over 4 with gaps: A 9>>>2 = 2, B -5>>>2 = -2
        dec_log2 = 4'd2;
        sample(24'd1, 24'hFFFFFF);
        check("avg_s1", 64'(m_axis_tvalid), 64'd0);
        step();
        sample(24'd2, 24'hFFFFFF);
        check("avg_s2", 64'(m_axis_tvalid), 64'd0);
        step(); step();
        sample(24'd3, 24'hFFFFFF);
        check("avg_s3", 64'(m_axis_tvalid), 64'd0);
        step();
        sample(24'd3, 24'hFFFFFE);
        check("avg_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("avg_tdata", 64'(m_axis_tdata), pk(24'd2, 24'hFFFFFE));
        step();
        check("avg_drain", 64'(m_axis_tvalid), 64'd0);

        // Back-pressure: 10 and 20 kept, 30 dropped
        dec_log2      = 4'd0;
        m_axis_tready = 1'b0;
        sample(24'd10, 24'd0);
        sample(24'd20, 24'd0);
        check("bp_no_ovf_yet", 64'(overflow), 64'd0);
        sample(24'd30, 24'd0);
        check("bp_ovf", 64'(overflow), 64'd1);
        check("bp_hold", 64'(m_axis_tdata), pk(24'd10, 24'd0));
        step();
        check("bp_stable", 64'(m_axis_tdata), pk(24'd10, 24'd0));
        m_axis_tready = 1'b1;
        step();
        check("bp_second", 64'(m_axis_tdata), pk(24'd20, 24'd0));
        step();
        check("bp_empty", 64'(m_axis_tvalid), 64'd0);
        check("bp_ovf_sticky", 64'(overflow), 64'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("bp_ovf_clear", 64'(overflow), 64'd0);

        // Full FIFO with simultaneous pop and push
        m_axis_tready = 1'b0;
        sample(24'd1, 24'd0);
        sample(24'd2, 24'd0);
        m_axis_tready = 1'b1;
        sample(24'd3, 24'd0);
        check("fp_no_ovf", 64'(overflow), 64'd0);
        check("fp_head2", 64'(m_axis_tdata), pk(24'd2, 24'd0));
        step();
        check("fp_head3", 64'(m_axis_tdata), pk(24'd3, 24'd0));
        step();
        check("fp_empty", 64'(m_axis_tvalid), 64'd0);

        // Exponent change mid-block: block of 8 (A=1..8), then block of 2
        dec_log2 = 4'd3;
        for (int i = 1; i <= 7; i++) begin
            if (i == 6) dec_log2 = 4'd1;
            sample(24'(i), 24'(-i));
            check("mb_wait", 64'(m_axis_tvalid), 64'd0);
        end
        sample(24'd8, 24'hFFFFF8);
        check("mb8_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("mb8_tdata", 64'(m_axis_tdata), pk(24'd4, 24'hFFFFFB));
        sample(24'd10, 24'hFFFFF6);
        check("mb2_wait", 64'(m_axis_tvalid), 64'd0);
        sample(24'd11, 24'hFFFFF5);
        check("mb2_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("mb2_tdata", 64'(m_axis_tdata), pk(24'd10, 24'hFFFFF5));
        step();

        // Reset mid-block with FIFO contents
        dec_log2      = 4'd0;
        m_axis_tready = 1'b0;
        sample(24'h77, 24'd0);
        check("rs_fifo_loaded", 64'(m_axis_tvalid), 64'd1);
        dec_log2 = 4'd2;
        sample(24'd1, 24'd0);
        aresetn = 1'b0;
        #1;
        check("rs_async_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rs_async_tdata", 64'(m_axis_tdata), 64'd0);
        step(); step();
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        dec_log2      = 4'd1;
        sample(24'd4, 24'd0);
        check("rs_fresh_wait", 64'(m_axis_tvalid), 64'd0);
        sample(24'd6, 24'd0);
        check("rs_fresh_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("rs_fresh_tdata", 64'(m_axis_tdata), pk(24'd5, 24'd0));
        step();

        // Exponent above the maximum clamps to 1024-sample blocks
        dec_log2 = 4'd15;
        for (int i = 0; i < 1023; i++) begin
            sample(24'd1, 24'hFFFFFF);
        end
        check("clamp_wait", 64'(m_axis_tvalid), 64'd0);
        sample(24'd1, 24'hFFFFFF);
        check("clamp_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("clamp_tdata", 64'(m_axis_tdata), pk(24'd1, 24'hFFFFFF));
        check("final_ovf", 64'(overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iq_axis_decimator.md
Name: iq_axis_decimator

Overview:
- Consumes the packed two-channel word from the channel-combine stage: channel A in bits [23:0], channel B in bits [47:24], both two's-complement.
- Boxcar-averages each channel over 2^dec_log2 samples.
- Emits the averaged, identically packed word on an AXI4-Stream master toward the DMA/stream writer.
- A 2-entry output FIFO absorbs downstream back-pressure; results that cannot be stored are dropped and flagged.

Parameters:
- DATA_WIDTH, 48, packed word width; always 2*CH_WIDTH.
- CH_WIDTH, 24, per-channel signed sample width.
- MAX_LOG2_DEC, 10, maximum decimation exponent; accumulator width is CH_WIDTH+MAX_LOG2_DEC (34).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_data  in  DATA_WIDTH  packed input word {B, A}.
- s_valid  in  1  s_data holds a new sample this cycle. There is no ready signal; the input is never stalled.
- dec_log2  in  4  decimation exponent; values above MAX_LOG2_DEC are clamped to MAX_LOG2_DEC.
- clear_ovf  in  1  synchronous clear of overflow.
- m_axis_tdata  out  DATA_WIDTH  averaged packed word {B_avg, A_avg}.
- m_axis_tvalid  out  1  AXI-S valid.
- m_axis_tready  in  1  AXI-S ready.
- overflow  out  1  sticky flag: at least one result was dropped.

Behaviour:
- Reset (aresetn low, asynchronous) clears all state:
  - accumulators = 0, sample counter = 0, FIFO empty;
  - m_axis_tvalid = 0, m_axis_tdata = 0, overflow = 0;
  - latched exponent k = clamp(dec_log2) is taken on the first clock after release.
- Reset asserted mid-block discards the partial sums and any FIFO contents.
- Exponent latch:
  - k is re-latched from dec_log2 only when the counter is 0 and a sample is accepted (block start).
  - A change to dec_log2 mid-block takes effect at the next block start.
- Accumulation, on each cycle with s_valid = 1:
  - sign-extend A and B to 34 bits and add them to accA and accB;
  - increment the counter;
  - cycles with s_valid = 0 change nothing.
- Block end: the sample arriving with counter == 2^k - 1 is the last of the block.
  - Results are A_avg = (accA + A) >>> k and B_avg = (accB + B) >>> k: arithmetic shift, floor rounding, low CH_WIDTH bits kept.
  - The result always fits in CH_WIDTH bits.
  - On the same edge: accumulators and counter return to 0, and the result is pushed into the FIFO.
  - k = 0 is pass-through: every valid sample is a block end.
- Latency: a pushed result appears on m_axis_tdata with m_axis_tvalid = 1 on the cycle after the edge at which the last sample was accepted. With k = 0, output lags input by exactly 1 cycle.
- FIFO, depth 2, first-word-fall-through:
  - m_axis_tvalid = (FIFO not empty); m_axis_tdata = head entry; m_axis_tdata is 0 while the FIFO is empty.
  - Pop occurs on a cycle where m_axis_tvalid and m_axis_tready are both 1.
  - tdata is held stable while tvalid = 1 and tready = 0 (AXI-S rule).
  - Push and pop may occur on the same cycle at any occupancy. When full, a simultaneous pop frees the slot and the push is accepted.
- Drop:
  - A push occurs when the FIFO is full and no pop happens that cycle: the new result is discarded, the FIFO is unchanged, and overflow is set to 1 on that edge.
  - Accumulation continues unaffected.
- Overflow clear:
  - clear_ovf = 1 clears overflow on the next edge.
  - If a drop occurs on the same edge, set wins and overflow stays 1.
- No tlast/tkeep outputs; one transfer per result.

Test Plan:
- Reset/idle: hold aresetn = 0, then release with s_valid = 0 for 20 cycles -> m_axis_tvalid = 0, m_axis_tdata = 0, overflow = 0 throughout.
- Pass-through: dec_log2 = 0, tready = 1, s_valid = 1 with A = 0x000005, B = 0xFFFFFD -> next cycle tdata = 0xFFFFFD_000005, tvalid = 1. Back-to-back samples produce one transfer per cycle.
- Averaging and rounding: dec_log2 = 2, A samples 1, 2, 3, 3 and B samples -1, -1, -1, -2 (with gaps in s_valid) -> a single output of A = 2 (9>>>2) and B = -2 (-5>>>2 floor), tvalid asserted 1 cycle after the 4th valid sample.
- Back-pressure: dec_log2 = 0, tready = 0, three valid samples 10, 20, 30 -> FIFO holds 10 and 20, 30 is dropped, overflow = 1. Raising tready then yields 10, then 20, then tvalid = 0. Asserting clear_ovf then makes overflow = 0.
- Full with simultaneous pop/push: FIFO full, tready = 1 in the same cycle as a new result -> no drop, overflow stays 0, output order preserved.
- Mid-block exponent change and reset: dec_log2 switched 3 -> 1 after 5 samples -> the current block still completes at 8 samples, and the next block completes at 2. Asserting aresetn = 0 mid-block then gives no output from the partial sums and a fresh count after release.
